// File: rtl/mm_seq_ctrl_pkg.sv
// ============================================================
// mm_seq_ctrl_pkg : shared state encoding and defaults
// Rev 1.0
// ============================================================
`default_nettype none

package mm_seq_ctrl_pkg;

    localparam int DEF_N      = 3;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Row-major flat index into an n-wide matrix.
    function automatic int flat_idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mm_seq_ctrl_if.sv
// ============================================================
// mm_seq_ctrl_if : control and strobe bundle of the sequencer
// Rev 1.0
// ============================================================
`default_nettype none

interface mm_seq_ctrl_if #(
    parameter int ADDR_W = mm_seq_ctrl_pkg::DEF_ADDR_W
);
    logic              start;
    logic              abort;
    logic              step_mode;
    logic              step;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] c_addr;
    logic              mac_clr;
    logic              mac_en;
    logic              c_we;
    logic              tick;

    modport master (
        output start, abort, step_mode, step,
        input  busy, done, a_addr, b_addr, c_addr, mac_clr, mac_en, c_we, tick
    );

    modport slave (
        input  start, abort, step_mode, step,
        output busy, done, a_addr, b_addr, c_addr, mac_clr, mac_en, c_we, tick
    );
endinterface

`default_nettype wire

// File: rtl/mm_tick_gen.sv
// ============================================================
// mm_tick_gen : DIV-cycle step enable, replaces a derived slow clock
// Rev 1.0
// ============================================================
`default_nettype none

module mm_tick_gen #(
    parameter int DIV   = 1,
    parameter int CNT_W = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !run || (cnt == LAST_CNT)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = run && (cnt == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/mm_seq_ctrl.sv
// ============================================================
// mm_seq_ctrl : walks (i,j,k) of C = A*B, issues addresses and MAC strobes
// Rev 1.0
// ============================================================
`default_nettype none

module mm_seq_ctrl
    import mm_seq_ctrl_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV    = 1,
    parameter int CNT_W  = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    mm_seq_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] k_idx;
    logic              busy_reg;
    logic              done_reg;

    logic run;
    logic tick;
    logic adv;
    logic abort_now;
    logic go_idle;

    assign run       = (state != S_IDLE);
    assign abort_now = bus.abort && run;
    assign go_idle   = abort_now || (state == S_DONE);
    assign adv       = (state inside {S_CLEAR, S_ACCUM, S_WRITE})
                       && (bus.step_mode ? bus.step : tick);

    mm_tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (go_idle),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            col      <= '0;
            k_idx    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (abort_now) begin
            state    <= S_IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_CLEAR;
                        row      <= '0;
                        col      <= '0;
                        k_idx    <= '0;
                        busy_reg <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (adv) state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (adv) begin
                        if (k_idx == LAST) begin
                            k_idx <= '0;
                            state <= S_WRITE;
                        end else begin
                            k_idx <= k_idx + ADDR_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (adv) begin
                        if (col < LAST) begin
                            col   <= col + ADDR_W'(1);
                            state <= S_CLEAR;
                        end else if (row < LAST) begin
                            col   <= '0;
                            row   <= row + ADDR_W'(1);
                            state <= S_CLEAR;
                        end else begin
                            state    <= S_DONE;
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes follow the step enable directly so they land in the advancing cycle.
    assign bus.mac_clr = (state == S_CLEAR) && adv && !bus.abort;
    assign bus.mac_en  = (state == S_ACCUM) && adv && !bus.abort;
    assign bus.c_we    = (state == S_WRITE) && adv && !bus.abort;

    assign bus.a_addr = ADDR_W'(flat_idx(int'(row),   int'(k_idx), N));
    assign bus.b_addr = ADDR_W'(flat_idx(int'(k_idx), int'(col),   N));
    assign bus.c_addr = ADDR_W'(flat_idx(int'(row),   int'(col),   N));

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.tick = tick;

endmodule

`default_nettype wire

// File: tb/tb_mm_seq_ctrl.sv
// ============================================================
// tb_mm_seq_ctrl : scoreboard bench for three sequencer configurations
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mm_seq_ctrl;

    localparam int K_CLR = 8;
    localparam int K_EN  = 4;
    localparam int K_WE  = 2;
    localparam int K_DN  = 1;

    typedef struct {
        int dut;
        int kind;
        int a;
        int b;
        int c;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 1;   // index of the next rising edge
    int   total = 0;
    int   bad = 0;
    ev_t  q[$];

    // N=2 per-element (a_k0, b_k0, a_k1, b_k1, c) in order (0,0)(0,1)(1,0)(1,1)
    int tab2 [4][5] = '{'{0, 0, 1, 2, 0}, '{0, 1, 1, 3, 1},
                        '{2, 0, 3, 2, 2}, '{2, 1, 3, 3, 3}};

    mm_seq_ctrl_if #(.ADDR_W(4)) bus0 ();
    mm_seq_ctrl_if #(.ADDR_W(4)) bus1 ();
    mm_seq_ctrl_if #(.ADDR_W(4)) bus2 ();

    mm_seq_ctrl #(.N(2), .ADDR_W(4), .DIV(1), .CNT_W(27)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mm_seq_ctrl #(.N(2), .ADDR_W(4), .DIV(4), .CNT_W(27)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mm_seq_ctrl #(.N(3), .ADDR_W(4), .DIV(1), .CNT_W(27)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] obs [3];
    assign obs[0] = {bus0.mac_clr, bus0.mac_en, bus0.c_we, bus0.done, bus0.a_addr, bus0.b_addr, bus0.c_addr};
    assign obs[1] = {bus1.mac_clr, bus1.mac_en, bus1.c_we, bus1.done, bus1.a_addr, bus1.b_addr, bus1.c_addr};
    assign obs[2] = {bus2.mac_clr, bus2.mac_en, bus2.c_we, bus2.done, bus2.a_addr, bus2.b_addr, bus2.c_addr};

    // Monitor: every strobe or done pulse consumes one scoreboard entry.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                int  k;
                bit  ok;
                ev_t e;
                k = int'(obs[d][15:12]);
                if (k != 0) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL ev_unexpected dut=%0d cyc=%0d kind=%0d want=none", d, cyc, k);
                    end else begin
                        e  = q.pop_front();
                        ok = (e.dut == d) && (e.kind == k) && (e.cyc == cyc);
                        if (k == K_EN)
                            ok = ok && (int'(obs[d][11:8]) == e.a) && (int'(obs[d][7:4]) == e.b);
                        if (k == K_CLR || k == K_WE)
                            ok = ok && (int'(obs[d][3:0]) == e.c);
                        if (!ok) begin
                            bad++;
                            $display("FAIL ev dut=%0d cyc=%0d kind=%0d a=%0d b=%0d c=%0d want dut=%0d cyc=%0d kind=%0d a=%0d b=%0d c=%0d",
                                     d, cyc, k, obs[d][11:8], obs[d][7:4], obs[d][3:0],
                                     e.dut, e.cyc, e.kind, e.a, e.b, e.c);
                        end
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int kind, input int a, input int b, input int c, input int cy);
        ev_t e;
        e.dut = d; e.kind = kind; e.a = a; e.b = b; e.c = c; e.cyc = cy;
        q.push_back(e);
    endtask

    task automatic push_n2(input int d, input int first, input int spacing, input int nadv, input bit with_done);
        for (int n = 0; n < nadv; n++) begin
            int e;
            int cy;
            e  = n / 4;
            cy = first + spacing * n;
            case (n % 4)
                0:       push(d, K_CLR, 0, 0, tab2[e][4], cy);
                1:       push(d, K_EN, tab2[e][0], tab2[e][1], 0, cy);
                2:       push(d, K_EN, tab2[e][2], tab2[e][3], 0, cy);
                default: push(d, K_WE, 0, 0, tab2[e][4], cy);
            endcase
        end
        if (with_done) push(d, K_DN, 0, 0, 0, first + spacing * (nadv - 1) + 1);
    endtask

    task automatic push_n3(input int d, input int first, input int nadv, input bit with_done);
        for (int n = 0; n < nadv; n++) begin
            int e, ph, i, j;
            e  = n / 5;
            ph = n % 5;
            i  = e / 3;
            j  = e % 3;
            if (ph == 0)      push(d, K_CLR, 0, 0, 3 * i + j, first + n);
            else if (ph == 4) push(d, K_WE, 0, 0, 3 * i + j, first + n);
            else              push(d, K_EN, 3 * i + ph - 1, 3 * (ph - 1) + j, 0, first + n);
        end
        if (with_done) push(d, K_DN, 0, 0, 0, first + nadv);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        check({name, "_pending"}, q.size(), 0);
        q.delete();
        repeat (3) next_cycle();
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        bus0.start = 0; bus0.abort = 0; bus0.step_mode = 0; bus0.step = 0;
        bus1.start = 0; bus1.abort = 0; bus1.step_mode = 0; bus1.step = 0;
        bus2.start = 0; bus2.abort = 0; bus2.step_mode = 0; bus2.step = 0;
        repeat (2) next_cycle();

        check("rst_busy", int'(bus0.busy), 0);
        check("rst_done", int'(bus0.done), 0);
        check("rst_strobes", int'({bus0.mac_clr, bus0.mac_en, bus0.c_we}), 0);
        check("rst_addr", int'({bus0.a_addr, bus0.b_addr, bus0.c_addr}), 0);
        check("rst_tick", int'(bus0.tick), 0);
        rst_n = 1'b1;
        next_cycle();

        // N=2, DIV=1 run: 16 advances from t+1, done at t+17
        t = cyc; bus0.start = 1; next_cycle(); bus0.start = 0;
        check("run_busy", int'(bus0.busy), 1);
        push_n2(0, t + 1, 1, 16, 1);
        drain("run_n2", 40);
        check("run_idle", int'(bus0.busy), 0);

        // N=2, DIV=4: strobes every 4 cycles, done at t+65; stray step ignored
        t = cyc; bus1.start = 1; next_cycle(); bus1.start = 0;
        push_n2(1, t + 4, 4, 16, 1);
        while (cyc <= t + 8) begin
            check("div4_tick", int'(bus1.tick), ((cyc - t) % 4 == 0) ? 1 : 0);
            bus1.step = (cyc == t + 1);
            next_cycle();
        end
        bus1.step = 0;
        drain("run_div4", 100);

        // N=2 step mode: pulses every 5 cycles, done one cycle after the last
        bus0.step_mode = 1;
        t = cyc; bus0.start = 1; next_cycle(); bus0.start = 0;
        push_n2(0, t + 3, 5, 16, 1);
        for (int n = 0; n < 16; n++) begin
            while (cyc < t + 3 + 5 * n) next_cycle();
            bus0.step = 1;
            next_cycle();
            bus0.step = 0;
        end
        drain("step", 10);
        bus0.step_mode = 0;

        // N=3 abort in the second ACCUM of (1,1)
        t = cyc; bus2.start = 1; next_cycle(); bus2.start = 0;
        push_n3(2, t + 1, 22, 0);
        while (cyc < t + 23) next_cycle();
        check("abort_busy_before", int'(bus2.busy), 1);
        bus2.abort = 1; next_cycle(); bus2.abort = 0;
        check("abort_busy_after", int'(bus2.busy), 0);
        check("abort_done", int'(bus2.done), 0);
        repeat (4) next_cycle();
        drain("abort", 5);

        t = cyc; bus2.start = 1; next_cycle(); bus2.start = 0;
        push_n3(2, t + 1, 45, 1);
        drain("restart_n3", 80);

        // Reset asserted mid-WRITE of element (0,1)
        t = cyc; bus0.start = 1; next_cycle(); bus0.start = 0;
        push_n2(0, t + 1, 1, 7, 0);
        while (cyc < t + 8) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(bus0.busy), 0);
        check("arst_cwe", int'(bus0.c_we), 0);
        check("arst_strobes", int'({bus0.mac_clr, bus0.mac_en, bus0.done, bus0.tick}), 0);
        check("arst_addr", int'({bus0.a_addr, bus0.b_addr, bus0.c_addr}), 0);
        check("arst_pending", q.size(), 0);
        q.delete();
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("arst_idle", int'(bus0.busy), 0);

        t = cyc; bus0.start = 1; next_cycle(); bus0.start = 0;
        push_n2(0, t + 1, 1, 16, 1);
        drain("post_reset", 40);

        // Extra start while busy and during DONE both ignored
        t = cyc; bus0.start = 1; next_cycle(); bus0.start = 0;
        push_n2(0, t + 1, 1, 16, 1);
        while (cyc < t + 5) next_cycle();
        bus0.start = 1; next_cycle(); bus0.start = 0;
        while (cyc < t + 17) next_cycle();
        check("done_cycle", int'(bus0.done), 1);
        bus0.start = 1; next_cycle(); bus0.start = 0;
        check("after_done_busy", int'(bus0.busy), 0);
        next_cycle();
        check("after_done_busy2", int'(bus0.busy), 0);
        drain("ignore_start", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
